// File: rtl/qos_pkg.sv
// Shared types and defaults for the QoS virtual-channel arbiter.
package qos_pkg;
  localparam int NUM_VC  = 4;
  localparam int VC_ID_W = 2;

  localparam int DEF_W0 = 4;
  localparam int DEF_W1 = 3;
  localparam int DEF_W2 = 2;
  localparam int DEF_W3 = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    STALL = 2'd2
  } arb_state_t;
endpackage

// File: rtl/vc_rr_next.sv
// Finds the next non-empty VC after the active one, searching +1..+4 with wrap.
module vc_rr_next
  import qos_pkg::*;
(
  input  logic [NUM_VC-1:0]  i_empty,
  input  logic [VC_ID_W-1:0] i_active_vc,
  output logic [VC_ID_W-1:0] o_next_vc,
  output logic               o_found
);

  logic [VC_ID_W-1:0] w_idx;

  // Scan farthest first so the nearest non-empty VC is the last one written.
  always_comb begin
    o_next_vc = i_active_vc;
    o_found   = 1'b0;
    w_idx     = '0;
    for (int k = NUM_VC; k >= 1; k--) begin
      w_idx = i_active_vc + VC_ID_W'(k);
      if (!i_empty[w_idx]) begin
        o_next_vc = w_idx;
        o_found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qos_vc_arbiter.sv
// Weighted round-robin arbiter: pops per-class FIFOs by credit and pushes
// class-tagged words into the egress FIFO through a two-stage pipe.
module qos_vc_arbiter
  import qos_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int W0     = DEF_W0,
  parameter int W1     = DEF_W1,
  parameter int W2     = DEF_W2,
  parameter int W3     = DEF_W3
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_VC-1:0]           i_empty,
  input  logic [NUM_VC*DATA_W-1:0]    i_dato_vc,
  input  logic                        i_almost_full,
  output logic [NUM_VC-1:0]           o_pop,
  output logic                        o_push_out,
  output logic [DATA_W+VC_ID_W-1:0]   o_dato_out,
  output logic [VC_ID_W-1:0]          o_active_vc
);

  arb_state_t                  r_state;
  logic [VC_ID_W-1:0]          r_active_vc;
  logic [3:0]                  r_credit;
  logic                        r_s1_valid;
  logic [VC_ID_W-1:0]          r_s1_vc;
  logic                        r_push;
  logic [DATA_W+VC_ID_W-1:0]   r_dato;

  logic                        w_can_move;
  logic                        w_pop_any;
  logic                        w_found;
  logic [VC_ID_W-1:0]          w_next_vc;
  logic [3:0]                  w_reload;

  function automatic logic [3:0] weight_of(input logic [VC_ID_W-1:0] vc);
    case (vc)
      2'd0:    return 4'(W0);
      2'd1:    return 4'(W1);
      2'd2:    return 4'(W2);
      default: return 4'(W3);
    endcase
  endfunction

  vc_rr_next u_rr_next (
    .i_empty     (i_empty),
    .i_active_vc (r_active_vc),
    .o_next_vc   (w_next_vc),
    .o_found     (w_found)
  );

  assign w_reload   = weight_of(w_next_vc);
  assign w_can_move = (r_state != STALL) && !i_almost_full;
  // Reset gates the pop so the FIFOs see no request while the arbiter is held.
  assign w_pop_any  = i_rst_n && w_can_move && !i_empty[r_active_vc] && (r_credit != 4'd0);

  always_comb begin
    o_pop = '0;
    o_pop[r_active_vc] = w_pop_any;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_active_vc <= '0;
      r_credit    <= 4'(W0);
      r_s1_valid  <= 1'b0;
      r_s1_vc     <= '0;
      r_push      <= 1'b0;
      r_dato      <= '0;
    end else begin
      if (i_almost_full)
        r_state <= STALL;
      else if (i_empty != '1)
        r_state <= SERVE;
      else
        r_state <= IDLE;

      // Last credit: hand over now so the next VC pops next cycle with no bubble.
      if (w_pop_any) begin
        if (r_credit <= 4'd1) begin
          r_active_vc <= w_next_vc;
          r_credit    <= w_reload;
        end else begin
          r_credit <= r_credit - 4'd1;
        end
      end else if (w_can_move && i_empty[r_active_vc] && w_found) begin
        r_active_vc <= w_next_vc;
        r_credit    <= w_reload;
      end

      r_s1_valid <= w_pop_any;
      r_s1_vc    <= r_active_vc;
      r_push     <= r_s1_valid;
      if (r_s1_valid)
        r_dato <= {r_s1_vc, i_dato_vc[r_s1_vc*DATA_W +: DATA_W]};
    end
  end

  assign o_push_out  = r_push;
  assign o_dato_out  = r_dato;
  assign o_active_vc = r_active_vc;

endmodule

// File: tb/tb_qos_vc_arbiter.sv
// Bench for qos_vc_arbiter: FIFO models feed the DUT, a scoreboard checks egress words and timing.
module tb_qos_vc_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  empty;
  logic [15:0] dato_vc;
  logic        af;
  logic [3:0]  pop;
  logic        push_out;
  logic [5:0]  dato_out;
  logic [1:0]  active_vc;

  typedef struct {
    logic [5:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] fifo_q [4][$];
  int         log_vc[$];
  int         log_act[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  bit         last_push;

  always #5 clk = ~clk;

  qos_vc_arbiter dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_empty       (empty),
    .i_dato_vc     (dato_vc),
    .i_almost_full (af),
    .o_pop         (pop),
    .o_push_out    (push_out),
    .o_dato_out    (dato_out),
    .o_active_vc   (active_vc)
  );

  task automatic update_empty();
    for (int i = 0; i < 4; i++) empty[i] = (fifo_q[i].size() == 0);
  endtask

  task automatic run_cycle();
    logic [3:0] pop_s;
    logic [3:0] rd [4];
    bit         rdv [4];
    logic [3:0] w;
    exp_t       e;
    int         vc;
    @(negedge clk);
    last_push = (push_out === 1'b1);
    if (push_out === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL push_unexpected cyc=%0d got=%h expected=no push", cyc, dato_out);
      end else begin
        e = sb.pop_front();
        if (dato_out !== e.data || cyc != e.cyc) begin
          n_err++;
          $display("FAIL push_data got=%h@cyc%0d expected=%h@cyc%0d", dato_out, cyc, e.data, e.cyc);
        end
      end
    end
    pop_s = pop;
    log_act.push_back(int'(active_vc));
    n_cmp++;
    if ($countones(pop_s) > 1 || $isunknown(pop_s)) begin
      n_err++;
      $display("FAIL pop_onehot cyc=%0d got=%b expected=at most one bit", cyc, pop_s);
    end
    vc = 4;
    for (int i = 0; i < 4; i++) begin
      rdv[i] = 1'b0;
      rd[i]  = '0;
      if (pop_s[i] === 1'b1) begin
        vc = i;
        n_cmp++;
        if (fifo_q[i].size() == 0) begin
          n_err++;
          $display("FAIL pop_underflow cyc=%0d vc=%0d got=pop expected=no pop", cyc, i);
        end else begin
          w      = fifo_q[i].pop_front();
          rd[i]  = w;
          rdv[i] = 1'b1;
          e.data = {2'(i), w};
          e.cyc  = cyc + 2;
          sb.push_back(e);
        end
      end
    end
    log_vc.push_back(vc);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (rdv[i]) dato_vc[i*4 +: 4] = rd[i];
    update_empty();
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    af    = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) fifo_q[i].delete();
    log_vc.delete();
    log_act.delete();
    dato_vc = '0;
    update_empty();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic drain();
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 120) begin
      run_cycle();
      n++;
      done = (sb.size() == 0) && (empty == 4'hF);
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL drain got=%0d words left expected=0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    af      = 1'b0;
    empty   = 4'h0;
    dato_vc = '0;
    #2;
    n_cmp++; if (pop !== 4'h0)      begin n_err++; $display("FAIL reset_pop got=%b expected=0000", pop); end
    n_cmp++; if (push_out !== 1'b0) begin n_err++; $display("FAIL reset_push got=%b expected=0", push_out); end
    n_cmp++; if (dato_out !== 6'h0) begin n_err++; $display("FAIL reset_dato got=%h expected=00", dato_out); end
    n_cmp++; if (active_vc !== 2'd0) begin n_err++; $display("FAIL reset_active got=%0d expected=0", active_vc); end
  endtask

  task automatic test_single_vc();
    int exp_l[10];
    exp_l = '{0, 0, 0, 0, 0, 0, 4, 4, 4, 4};
    do_reset();
    for (int k = 1; k <= 6; k++) fifo_q[0].push_back(4'(k));
    update_empty();
    repeat (10) run_cycle();
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (log_vc[k] != exp_l[k]) begin
        n_err++;
        $display("FAIL single_order cyc=%0d got=%0d expected=%0d", k, log_vc[k], exp_l[k]);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL single_pushes got=%0d pending expected=0", sb.size()); end
  endtask

  task automatic test_all_vcs();
    int exp_l[10];
    exp_l = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 10; k++) fifo_q[i].push_back(4'($urandom_range(0, 15)));
    update_empty();
    repeat (20) run_cycle();
    for (int k = 0; k < 20; k++) begin
      n_cmp++;
      if (log_vc[k] != exp_l[k % 10]) begin
        n_err++;
        $display("FAIL wrr_order cyc=%0d got=%0d expected=%0d", k, log_vc[k], exp_l[k % 10]);
      end
    end
    drain();
  endtask

  task automatic test_skip_wrap();
    int exp_l[9];
    exp_l = '{4, 1, 1, 1, 3, 1, 1, 1, 3};
    do_reset();
    for (int k = 0; k < 9; k++) fifo_q[1].push_back(4'($urandom_range(0, 15)));
    for (int k = 0; k < 3; k++) fifo_q[3].push_back(4'($urandom_range(0, 15)));
    update_empty();
    repeat (9) run_cycle();
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if (log_vc[k] != exp_l[k]) begin
        n_err++;
        $display("FAIL skip_order cyc=%0d got=%0d expected=%0d", k, log_vc[k], exp_l[k]);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    int exp_l[12];
    int n_push_af;
    exp_l = '{0, 0, 4, 4, 4, 4, 4, 0, 0, 1, 1, 1};
    n_push_af = 0;
    do_reset();
    for (int k = 0; k < 6; k++) fifo_q[0].push_back(4'($urandom_range(0, 15)));
    for (int k = 0; k < 3; k++) fifo_q[1].push_back(4'($urandom_range(0, 15)));
    update_empty();
    for (int c = 0; c < 12; c++) begin
      af = (c >= 2 && c <= 5);
      run_cycle();
      if (c >= 2 && c <= 5 && last_push) n_push_af++;
    end
    af = 1'b0;
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (log_vc[k] != exp_l[k]) begin
        n_err++;
        $display("FAIL bp_order cyc=%0d got=%0d expected=%0d", k, log_vc[k], exp_l[k]);
      end
    end
    n_cmp++;
    if (n_push_af != 2) begin n_err++; $display("FAIL bp_inflight got=%0d expected=2", n_push_af); end
    drain();
  endtask

  task automatic test_early_empty();
    int exp_l[8];
    exp_l = '{0, 0, 4, 1, 1, 1, 1, 1};
    do_reset();
    for (int k = 0; k < 2; k++) fifo_q[0].push_back(4'($urandom_range(0, 15)));
    for (int k = 0; k < 5; k++) fifo_q[1].push_back(4'($urandom_range(0, 15)));
    update_empty();
    repeat (8) run_cycle();
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (log_vc[k] != exp_l[k]) begin
        n_err++;
        $display("FAIL early_order cyc=%0d got=%0d expected=%0d", k, log_vc[k], exp_l[k]);
      end
    end
    n_cmp++;
    if (log_act[3] != 1) begin n_err++; $display("FAIL early_grant got=%0d expected=1", log_act[3]); end
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 6; k++) fifo_q[0].push_back(4'(k + 8));
    update_empty();
    repeat (3) run_cycle();
    n_cmp++;
    if (push_out !== 1'b1) begin n_err++; $display("FAIL mid_prepush got=%b expected=1", push_out); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (push_out !== 1'b0)  begin n_err++; $display("FAIL mid_push got=%b expected=0", push_out); end
    n_cmp++; if (pop !== 4'h0)       begin n_err++; $display("FAIL mid_pop got=%b expected=0000", pop); end
    n_cmp++; if (dato_out !== 6'h0)  begin n_err++; $display("FAIL mid_dato got=%h expected=00", dato_out); end
    n_cmp++; if (active_vc !== 2'd0) begin n_err++; $display("FAIL mid_active got=%0d expected=0", active_vc); end
    sb.delete();
    for (int i = 0; i < 4; i++) fifo_q[i].delete();
    update_empty();
    repeat (2) begin
      run_cycle();
      n_cmp++;
      if (push_out !== 1'b0) begin n_err++; $display("FAIL mid_hold_push got=%b expected=0", push_out); end
    end
    rst_n = 1'b1;
    repeat (4) begin
      run_cycle();
      n_cmp++;
      if (push_out !== 1'b0) begin n_err++; $display("FAIL mid_stale_push got=%b expected=0", push_out); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_vc();
    test_all_vcs();
    test_skip_wrap();
    test_backpressure();
    test_early_empty();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
